// File: rtl/rtc_bus_controller.sv
// Bus master for the external RTC's multiplexed A/D bus: nine-register write and read bursts.
// Latency: a burst starts two cycles after a request edge and lasts 36*PHASE_CYC cycles.
// Backpressure: none; requests arriving while busy are held as pending flags and merged.
module rtc_bus_controller #(
    parameter int PHASE_CYC   = 4,
    parameter int READ_PERIOD = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_req,
    input  logic       rd_req,
    input  logic [7:0] ano,
    input  logic [7:0] mes,
    input  logic [7:0] dia,
    input  logic [7:0] horas,
    input  logic [7:0] minutos,
    input  logic [7:0] segundos,
    input  logic [7:0] ht,
    input  logic [7:0] mt,
    input  logic [7:0] st,
    output logic [7:0] anole,
    output logic [7:0] mesle,
    output logic [7:0] diale,
    output logic [7:0] horasle,
    output logic [7:0] minutosle,
    output logic [7:0] segundosle,
    output logic [7:0] htle,
    output logic [7:0] mtle,
    output logic [7:0] stle,
    output logic       listo_es,
    output logic       busy,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       ad_sel
);

    typedef enum logic [2:0] {S_IDLE, S_A_STB, S_A_REC, S_D_STB, S_D_REC} state_t;

    localparam logic [7:0]  PH_LAST  = 8'(PHASE_CYC - 1);
    localparam logic [31:0] PER_LAST = 32'(READ_PERIOD - 1);
    localparam bit          AUTO_RD  = (READ_PERIOD != 0);

    state_t      state_q, state_d;
    logic [7:0]  phase_q, phase_d;
    logic [3:0]  idx_q, idx_d;
    logic [31:0] per_q, per_d;
    logic        rd_burst_q, rd_burst_d;
    logic        wr_pend_q, wr_pend_d;
    logic        rd_pend_q, rd_pend_d;
    logic        wr_req_q;
    logic        busy_q, busy_d;
    logic        listo_q, listo_d;
    logic [7:0]  shadow_q [9];
    logic [7:0]  shadow_d [9];
    logic [7:0]  snap_q [9];
    logic [7:0]  snap_d [9];

    logic wr_rise, per_hit, ph_last, last_idx;

    // RTC register address for each transfer slot.
    function automatic logic [7:0] reg_addr(input logic [3:0] i);
        case (i)
            4'd0:    return 8'h21;
            4'd1:    return 8'h22;
            4'd2:    return 8'h23;
            4'd3:    return 8'h24;
            4'd4:    return 8'h25;
            4'd5:    return 8'h26;
            4'd6:    return 8'h41;
            4'd7:    return 8'h42;
            4'd8:    return 8'h43;
            default: return 8'h00;
        endcase
    endfunction

    assign wr_rise  = wr_req & ~wr_req_q;
    assign per_hit  = AUTO_RD && (per_q == PER_LAST);
    assign ph_last  = (phase_q == PH_LAST);
    assign last_idx = (idx_q == 4'd8);

    // Next-state logic and pad decode. The output enable is raised one cycle ahead of an
    // address strobe and dropped one cycle ahead of a read strobe, so it never moves on a falling strobe.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        idx_d      = idx_q;
        rd_burst_d = rd_burst_q;
        busy_d     = busy_q;
        listo_d    = listo_q;
        wr_pend_d  = wr_pend_q | wr_rise;
        rd_pend_d  = rd_pend_q | rd_req | per_hit;
        per_d      = (!AUTO_RD || per_hit) ? 32'd0 : per_q + 32'd1;
        shadow_d   = shadow_q;
        snap_d     = snap_q;
        cs_n       = 1'b1;
        rd_n       = 1'b1;
        wr_n       = 1'b1;
        ad_sel     = 1'b1;
        ad_oe      = 1'b0;
        ad_out     = 8'h00;

        if (state_q != S_IDLE) begin
            phase_d = ph_last ? 8'd0 : phase_q + 8'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (wr_pend_q || rd_pend_q) begin
                    ad_oe  = 1'b1;
                    ad_out = reg_addr(4'd0);
                    state_d = S_A_STB;
                    idx_d   = 4'd0;
                    phase_d = 8'd0;
                    busy_d  = 1'b1;
                end
                if (wr_pend_q) begin
                    rd_burst_d  = 1'b0;
                    wr_pend_d   = wr_rise;
                    shadow_d[0] = segundos;
                    shadow_d[1] = minutos;
                    shadow_d[2] = horas;
                    shadow_d[3] = dia;
                    shadow_d[4] = mes;
                    shadow_d[5] = ano;
                    shadow_d[6] = st;
                    shadow_d[7] = mt;
                    shadow_d[8] = ht;
                end else if (rd_pend_q) begin
                    rd_burst_d = 1'b1;
                    rd_pend_d  = rd_req | per_hit;
                end
            end
            S_A_STB: begin
                cs_n   = 1'b0;
                wr_n   = 1'b0;
                ad_sel = 1'b0;
                ad_oe  = 1'b1;
                ad_out = reg_addr(idx_q);
                if (ph_last) state_d = S_A_REC;
            end
            S_A_REC: begin
                ad_sel = 1'b0;
                ad_oe  = !(rd_burst_q && ph_last);
                ad_out = reg_addr(idx_q);
                if (ph_last) state_d = S_D_STB;
            end
            S_D_STB: begin
                cs_n = 1'b0;
                if (rd_burst_q) begin
                    rd_n = 1'b0;
                end else begin
                    wr_n   = 1'b0;
                    ad_oe  = 1'b1;
                    ad_out = shadow_q[idx_q];
                end
                if (ph_last) begin
                    if (rd_burst_q) shadow_d[idx_q] = ad_in;
                    state_d = S_D_REC;
                end
            end
            S_D_REC: begin
                if (ph_last && !last_idx) begin
                    ad_oe  = 1'b1;
                    ad_out = reg_addr(idx_q + 4'd1);
                end else if (!rd_burst_q) begin
                    ad_out = shadow_q[idx_q];
                end
                if (ph_last) begin
                    if (last_idx) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        if (rd_burst_q) snap_d = shadow_q;
                        else            listo_d = 1'b1;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_A_STB;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (wr_rise) listo_d = 1'b0;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Counters, request flags, shadow and snapshot registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q    <= 8'd0;
            idx_q      <= 4'd0;
            per_q      <= 32'd0;
            rd_burst_q <= 1'b0;
            wr_pend_q  <= 1'b0;
            rd_pend_q  <= 1'b0;
            wr_req_q   <= 1'b0;
            busy_q     <= 1'b0;
            listo_q    <= 1'b0;
            shadow_q   <= '{default: 8'h00};
            snap_q     <= '{default: 8'h00};
        end else begin
            phase_q    <= phase_d;
            idx_q      <= idx_d;
            per_q      <= per_d;
            rd_burst_q <= rd_burst_d;
            wr_pend_q  <= wr_pend_d;
            rd_pend_q  <= rd_pend_d;
            wr_req_q   <= wr_req;
            busy_q     <= busy_d;
            listo_q    <= listo_d;
            shadow_q   <= shadow_d;
            snap_q     <= snap_d;
        end
    end

    assign busy       = busy_q;
    assign listo_es   = listo_q;
    assign segundosle = snap_q[0];
    assign minutosle  = snap_q[1];
    assign horasle    = snap_q[2];
    assign diale      = snap_q[3];
    assign mesle      = snap_q[4];
    assign anole      = snap_q[5];
    assign stle       = snap_q[6];
    assign mtle       = snap_q[7];
    assign htle       = snap_q[8];

endmodule

// File: tb/tb_rtc_bus_controller.sv
// Directed bench for rtc_bus_controller with a small RTC register-file model on the pad.
module tb_rtc_bus_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, a_reset, wr_req, rd_req;
    logic [7:0] ano, mes, dia, horas, minutos, segundos, ht, mt, st;
    logic [7:0] le [9];
    logic       listo_es, busy, ad_oe, cs_n, rd_n, wr_n, ad_sel;
    logic [7:0] ad_out, ad_in;

    logic [7:0] a_le [9];
    logic       a_listo, a_busy, a_oe, a_cs_n, a_rd_n, a_wr_n, a_sel;
    logic [7:0] a_ad_out;

    rtc_bus_controller #(.PHASE_CYC(4), .READ_PERIOD(0)) dut (
        .clk(clk), .reset(reset), .wr_req(wr_req), .rd_req(rd_req),
        .ano(ano), .mes(mes), .dia(dia), .horas(horas), .minutos(minutos),
        .segundos(segundos), .ht(ht), .mt(mt), .st(st),
        .segundosle(le[0]), .minutosle(le[1]), .horasle(le[2]), .diale(le[3]),
        .mesle(le[4]), .anole(le[5]), .stle(le[6]), .mtle(le[7]), .htle(le[8]),
        .listo_es(listo_es), .busy(busy), .ad_out(ad_out), .ad_oe(ad_oe),
        .ad_in(ad_in), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .ad_sel(ad_sel)
    );

    rtc_bus_controller #(.PHASE_CYC(4), .READ_PERIOD(200)) dut_ar (
        .clk(clk), .reset(a_reset), .wr_req(1'b0), .rd_req(1'b0),
        .ano(8'h00), .mes(8'h00), .dia(8'h00), .horas(8'h00), .minutos(8'h00),
        .segundos(8'h00), .ht(8'h00), .mt(8'h00), .st(8'h00),
        .segundosle(a_le[0]), .minutosle(a_le[1]), .horasle(a_le[2]), .diale(a_le[3]),
        .mesle(a_le[4]), .anole(a_le[5]), .stle(a_le[6]), .mtle(a_le[7]), .htle(a_le[8]),
        .listo_es(a_listo), .busy(a_busy), .ad_out(a_ad_out), .ad_oe(a_oe),
        .ad_in(8'h00), .cs_n(a_cs_n), .rd_n(a_rd_n), .wr_n(a_wr_n), .ad_sel(a_sel)
    );

    typedef struct {
        logic [7:0] ano, mes, dia, horas, minutos, segundos, ht, mt, st;
        int         exp_cyc;
    } vec_t;

    vec_t       vt [3];
    logic [7:0] exp_addr [9];
    int         tests = 0;
    int         fails = 0;

    // RTC model and bus monitor state.
    logic [7:0]  rtc_mem [256];
    logic [7:0]  addr_lat = 8'h00;
    logic [15:0] wlog [$];
    int          a_rise [$];
    logic        mon_en = 1'b0;
    int          cyc_n = 0, rd_falls = 0;
    int          viol_both = 0, viol_rd_oe = 0, viol_stable = 0, viol_oefall = 0, viol_snap = 0;
    logic        p_cs_n = 1'b1, p_rd_n = 1'b1, p_wr_n = 1'b1, p_oe = 1'b0, p_busy = 1'b0, a_p_busy = 1'b0;
    logic [7:0]  p_ad_out = 8'h00;
    logic [71:0] snap, p_snap = '0;

    assign snap  = {le[0], le[1], le[2], le[3], le[4], le[5], le[6], le[7], le[8]};
    assign ad_in = (!cs_n && !rd_n && ad_sel) ? rtc_mem[addr_lat] : 8'h00;

    always @(negedge clk) begin
        cyc_n++;
        if (mon_en) begin
            if (!rd_n && !wr_n) viol_both++;
            if (!rd_n && ad_oe) viol_rd_oe++;
            if (!wr_n && !p_wr_n && ad_out !== p_ad_out) viol_stable++;
            if (((p_cs_n && !cs_n) || (p_rd_n && !rd_n) || (p_wr_n && !wr_n)) && ad_oe !== p_oe)
                viol_oefall++;
            if (busy && p_busy && snap !== p_snap) viol_snap++;
            if (p_wr_n && !wr_n && ad_sel) wlog.push_back({addr_lat, ad_out});
            if (p_rd_n && !rd_n) rd_falls++;
            if (a_busy && !a_p_busy) a_rise.push_back(cyc_n);
        end
        if (!cs_n && !wr_n && !ad_sel) addr_lat = ad_out;
        if (!cs_n && !wr_n && ad_sel) rtc_mem[addr_lat] = ad_out;
        p_cs_n = cs_n; p_rd_n = rd_n; p_wr_n = wr_n; p_oe = ad_oe;
        p_ad_out = ad_out; p_busy = busy; p_snap = snap; a_p_busy = a_busy;
    end

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_busy(input logic lvl, input int budget, output int cyc);
        cyc = 0;
        while (busy !== lvl && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        if (busy !== lvl) begin
            tests++;
            fails++;
            $display("FAIL wait_busy: busy=%b, expected %b within %0d cycles", busy, lvl, budget);
        end
    endtask

    task automatic wait_dstb(input int budget);
        int c = 0;
        while (!(!cs_n && ad_sel) && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (!(!cs_n && ad_sel)) begin
            tests++;
            fails++;
            $display("FAIL wait_dstb: no data strobe within %0d cycles", budget);
        end
    endtask

    task automatic stage(input vec_t v, input logic [7:0] x);
        ano = v.ano ^ x; mes = v.mes ^ x; dia = v.dia ^ x; horas = v.horas ^ x;
        minutos = v.minutos ^ x; segundos = v.segundos ^ x;
        ht = v.ht ^ x; mt = v.mt ^ x; st = v.st ^ x;
    endtask

    function automatic logic [7:0] fld(input vec_t v, input int k);
        case (k)
            0: return v.segundos;
            1: return v.minutos;
            2: return v.horas;
            3: return v.dia;
            4: return v.mes;
            5: return v.ano;
            6: return v.st;
            7: return v.mt;
            default: return v.ht;
        endcase
    endfunction

    initial begin
        int c, base;
        vt[0] = '{8'h16, 8'h08, 8'h25, 8'h12, 8'h34, 8'h59, 8'h01, 8'h02, 8'h30, 144};
        vt[1] = '{8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h58, 8'h10, 8'h20, 8'h45, 144};
        vt[2] = '{8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 144};
        exp_addr = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
        for (int i = 0; i < 256; i++) rtc_mem[i] = 8'h00;

        reset = 1'b1; a_reset = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
        stage(vt[0], 8'h00);
        repeat (3) @(negedge clk);
        check("rst_strobes_sel", {cs_n, rd_n, wr_n, ad_sel}, 4'hF);
        check("rst_busy_listo_oe", {busy, listo_es, ad_oe}, 3'b000);
        check("rst_ad_out", ad_out, 8'h00);
        check("rst_snapshot", snap, 72'h0);
        reset = 1'b0; a_reset = 1'b0; mon_en = 1'b1;

        for (int v = 0; v < 3; v++) begin
            wlog.delete();
            stage(vt[v], 8'h00);
            wr_req = 1'b1;
            @(negedge clk);
            check($sformatf("v%0d_listo_clr", v), listo_es, 1'b0);
            wait_busy(1'b1, 10, c);
            stage(vt[v], 8'hFF);
            wait_busy(1'b0, 300, c);
            check($sformatf("v%0d_wr_cycles", v), c, vt[v].exp_cyc);
            check($sformatf("v%0d_listo_set", v), listo_es, 1'b1);
            check($sformatf("v%0d_wr_count", v), wlog.size(), 9);
            for (int k = 0; k < 9 && k < wlog.size(); k++)
                check($sformatf("v%0d_wr_pair%0d", v, k), wlog[k], {exp_addr[k], fld(vt[v], k)});
            wr_req = 1'b0;
            rd_req = 1'b1;
            @(negedge clk);
            rd_req = 1'b0;
            wait_busy(1'b1, 10, c);
            wait_busy(1'b0, 300, c);
            check($sformatf("v%0d_rd_cycles", v), c, vt[v].exp_cyc);
            for (int k = 0; k < 9; k++)
                check($sformatf("v%0d_snap%0d", v, k), le[k], fld(vt[v], k));
        end

        // Write rise and read pulse together: write first, read one idle cycle later.
        stage(vt[1], 8'h00);
        wr_req = 1'b1; rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        wait_busy(1'b1, 10, c);
        wait_dstb(40);
        check("simul_first_write", {wr_n, rd_n}, 2'b01);
        wait_busy(1'b0, 300, c);
        wait_busy(1'b1, 10, c);
        check("simul_gap", c, 1);
        wait_dstb(40);
        check("simul_second_read", {wr_n, rd_n}, 2'b10);
        wait_busy(1'b0, 300, c);
        wr_req = 1'b0;

        // Reset on the first cycle of the data strobe of idx 4 during a read.
        base = rd_falls;
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        c = 0;
        while (rd_falls != base + 5 && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("mid_on_rd_strobe", {rd_n, ad_sel, addr_lat}, {1'b0, 1'b1, 8'h25});
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_strobes", {cs_n, rd_n, wr_n}, 3'b111);
        check("mid_rst_oe_busy_listo", {ad_oe, busy, listo_es}, 3'b000);
        check("mid_rst_snapshot", snap, 72'h0);
        repeat (5) @(negedge clk);
        check("mid_rst_no_restart", busy, 1'b0);

        check("viol_rd_wr_both_low", viol_both, 0);
        check("viol_oe_during_read", viol_rd_oe, 0);
        check("viol_ad_out_unstable", viol_stable, 0);
        check("viol_oe_on_strobe_fall", viol_oefall, 0);
        check("viol_partial_snapshot", viol_snap, 0);

        check("auto_rise_count", a_rise.size() >= 3, 1'b1);
        for (int i = 1; i < 3 && i < a_rise.size(); i++)
            check($sformatf("auto_interval%0d", i), a_rise[i] - a_rise[i-1], 200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
